// File: rtl/matmul_result_serializer.sv
// ---------------------------------------------------------------------------
// matmul_result_serializer
//
// Captures the packed 3x3 matrix-multiply result on the rising edge of
// done_in. It then streams the result out one byte per valid/ready handshake,
// little-endian: element 0 low byte first, element N_ELEM-1 high byte last.
// A result that arrives while a frame is in flight is dropped and flagged on
// the sticky overrun output. The one exception is a result that arrives on
// the same cycle as the final byte's transfer: that result is accepted and
// starts the next frame with no bubble.
//
// Optional feature (macro RESULT_CHECKSUM_EN):
//   When defined, every frame carries one extra trailing byte. That byte is
//   the XOR of all payload bytes, and out_last marks it. When undefined, no
//   checksum logic exists.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   done_in    in   multiplier done; C_flat valid whenever done_in=1
//   C_flat     in   packed result, element k at [ELEM_W*k +: ELEM_W]
//   out_data   out  current output byte (0 when out_valid=0)
//   out_valid  out  out_data holds a valid byte
//   out_ready  in   consumer accepts the byte this cycle
//   out_last   out  final byte of the frame (qualified by out_valid)
//   busy       out  a frame is held / being transmitted
//   overrun    out  sticky: a result arrived while busy and was dropped
// ---------------------------------------------------------------------------
module matmul_result_serializer #(
  parameter int N_ELEM = 9,
  parameter int ELEM_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_in,
  input  logic [N_ELEM*ELEM_W-1:0] C_flat,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun
);

  localparam int N_BYTES = N_ELEM * ELEM_W / 8;
`ifdef RESULT_CHECKSUM_EN
  localparam int FRAME_LEN = N_BYTES + 1;
`else
  localparam int FRAME_LEN = N_BYTES;
`endif
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  if (ELEM_W % 8 != 0) begin : g_elem_w_check
    $error("ELEM_W must be a multiple of 8");
  end

  typedef enum logic {IDLE, SEND} state_e;

  state_e                   state_q;
  logic                     done_q;
  logic                     valid_q;
  logic                     overrun_q;
  logic [IDX_W-1:0]         idx_q;
  logic [N_BYTES*8-1:0]     shadow_q;
`ifdef RESULT_CHECKSUM_EN
  logic [7:0]               csum_q;

  function automatic logic [7:0] xor_bytes(input logic [N_BYTES*8-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int b = 0; b < N_BYTES; b++) acc ^= v[8*b +: 8];
    return acc;
  endfunction
`endif

  logic capture_ev;
  logic xfer;
  logic last_xfer;
  logic [7:0] byte_sel;

  // A done_in held high for several cycles yields exactly one capture.
  assign capture_ev = done_in & ~done_q;
  assign xfer       = valid_q & out_ready;
  assign last_xfer  = xfer & (idx_q == LAST_IDX);

  // Byte mux over registered state only; out_ready never reaches the outputs.
  always_comb begin
    // NOTE: default first so every path assigns byte_sel and no latch is inferred.
    byte_sel = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      if (idx_q == IDX_W'(b)) byte_sel = shadow_q[8*b +: 8];
    end
`ifdef RESULT_CHECKSUM_EN
    if (idx_q == IDX_W'(N_BYTES)) byte_sel = csum_q;
`endif
  end

  // NOTE: shadow_q is deliberately not reset (wide data, no control meaning);
  // gating out_data with valid_q gives the required zero output after reset.
  assign out_data  = valid_q ? byte_sel : 8'h00;
  assign out_valid = valid_q;
  assign out_last  = valid_q & (idx_q == LAST_IDX);
  assign busy      = (state_q == SEND);
  assign overrun   = overrun_q;

  // NOTE: non-blocking assignments throughout so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      done_q <= done_in;
      case (state_q)
        IDLE: begin
          if (capture_ev) begin
            shadow_q <= C_flat;
`ifdef RESULT_CHECKSUM_EN
            csum_q   <= xor_bytes(C_flat);
`endif
            idx_q    <= '0;
            valid_q  <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (last_xfer) begin
            idx_q <= '0;
            if (capture_ev) begin
              // Back-to-back frame: reload without dropping out_valid.
              shadow_q <= C_flat;
`ifdef RESULT_CHECKSUM_EN
              csum_q   <= xor_bytes(C_flat);
`endif
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            if (xfer) idx_q <= idx_q + IDX_W'(1);
            if (capture_ev) overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_result_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for matmul_result_serializer. It uses directed vectors with
// hand-computed expectations. Each scenario task drives its own stimulus and
// compares inline. Inputs change and outputs are sampled 1 ns after the
// rising clock edge.
// ---------------------------------------------------------------------------
module tb_matmul_result_serializer;

  localparam int N_ELEM  = 9;
  localparam int ELEM_W  = 16;
  localparam int N_BYTES = N_ELEM * ELEM_W / 8;
`ifdef RESULT_CHECKSUM_EN
  localparam int FRAME_LEN = N_BYTES + 1;
`else
  localparam int FRAME_LEN = N_BYTES;
`endif

  logic                     clk;
  logic                     rst;
  logic                     done_in;
  logic [N_ELEM*ELEM_W-1:0] C_flat;
  logic [7:0]               out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     busy;
  logic                     overrun;

  int checks;
  int errors;

  // Bytes seen by the consumer, filled by collect().
  logic [7:0] rx_data [$];
  logic       rx_last [$];
  int         stable_err;

  matmul_result_serializer #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done_in),
    .C_flat    (C_flat),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected byte i of a frame built from result c (little-endian + optional XOR).
  function automatic logic [7:0] exp_byte(input logic [N_ELEM*ELEM_W-1:0] c, input int i);
    logic [7:0] acc;
    if (i < N_BYTES) return c[8*i +: 8];
    acc = 8'h00;
    for (int b = 0; b < N_BYTES; b++) acc ^= c[8*b +: 8];
    return acc;
  endfunction

  // Rising edge of done_in for one cycle with result c.
  task automatic pulse_done(input logic [N_ELEM*ELEM_W-1:0] c);
    C_flat  = c;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  // Receive nbytes using a 4-cycle ready pattern (bit 0 first). It also counts
  // violations of output stability during stalls.
  task automatic collect(input int nbytes, input logic [3:0] pat,
                         input int max_cyc, output bit timed_out);
    int         c;
    bit         stalled;
    logic [7:0] hold_d;
    logic       hold_l;
    rx_data.delete();
    rx_last.delete();
    stable_err = 0;
    stalled    = 1'b0;
    hold_d     = 8'h00;
    hold_l     = 1'b0;
    c          = 0;
    while (rx_data.size() < nbytes && c < max_cyc) begin
      out_ready = pat[c % 4];
      if (stalled && (out_valid !== 1'b1 || out_data !== hold_d || out_last !== hold_l))
        stable_err++;
      if (out_valid === 1'b1 && out_ready) begin
        rx_data.push_back(out_data);
        rx_last.push_back(out_last);
        stalled = 1'b0;
      end else begin
        stalled = (out_valid === 1'b1);
        hold_d  = out_data;
        hold_l  = out_last;
      end
      c++;
      tick();
    end
    out_ready = 1'b0;
    timed_out = (rx_data.size() < nbytes);
  endtask

  // Compare collected bytes against frame c, starting at frame byte 'first'.
  task automatic check_frame(input string name, input logic [N_ELEM*ELEM_W-1:0] c,
                             input int first, input int n);
    checks++;
    if (rx_data.size() != n) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d", name, rx_data.size(), n);
    end
    for (int i = 0; i < n && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp_byte(c, first + i) ||
          rx_last[i] !== (first + i == FRAME_LEN - 1)) begin
        errors++;
        $display("FAIL %s byte%0d: got %h/last=%b expected %h/last=%b", name, first + i,
                 rx_data[i], rx_last[i], exp_byte(c, first + i), first + i == FRAME_LEN - 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, busy, overrun, out_last, out_data} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got v=%b b=%b o=%b l=%b d=%h expected all zero",
               out_valid, busy, overrun, out_last, out_data);
    end
  endtask

  task automatic test_single_frame();
    logic [N_ELEM*ELEM_W-1:0] c;
    bit to;
    c = '0;
    c[15:0]    = 16'h1234;
    c[143:128] = 16'hBEEF;
    out_ready = 1'b1;
    C_flat    = c;
    done_in   = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_pre: got out_valid=%b expected 0", out_valid);
    end
    tick();
    done_in = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_post: got v=%b b=%b expected 1 1", out_valid, busy);
    end
    collect(FRAME_LEN, 4'b1111, 100, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL single_timeout: got %0d bytes expected %0d", rx_data.size(), FRAME_LEN);
    end
    // Hand-computed bytes of this vector.
    checks++;
    if (rx_data.size() >= N_BYTES &&
        {rx_data[0], rx_data[1], rx_data[2], rx_data[15], rx_data[16], rx_data[17]}
          !== 48'h3412_0000_EFBE) begin
      errors++;
      $display("FAIL single_literal: got %h %h %h %h %h %h expected 34 12 00 00 ef be",
               rx_data[0], rx_data[1], rx_data[2], rx_data[15], rx_data[16], rx_data[17]);
    end
    check_frame("single", c, 0, FRAME_LEN);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got v=%b b=%b expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [N_ELEM*ELEM_W-1:0] c;
    bit to;
    for (int i = 0; i < N_BYTES; i++) c[8*i +: 8] = 8'(8'hA0 + i);
    pulse_done(c);
    collect(FRAME_LEN, 4'b1001, 200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bp_timeout: got %0d bytes expected %0d", rx_data.size(), FRAME_LEN);
    end
    check_frame("bp", c, 0, FRAME_LEN);
    checks++;
    if (stable_err != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stable_err);
    end
  endtask

  task automatic test_level_done();
    logic [N_ELEM*ELEM_W-1:0] c;
    bit to;
    int extra;
    for (int i = 0; i < N_BYTES; i++) c[8*i +: 8] = 8'(8'h5A ^ (i * 7));
    C_flat  = c;
    done_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    done_in = 1'b0;
    collect(FRAME_LEN, 4'b1111, 100, to);
    check_frame("level", c, 0, FRAME_LEN);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid !== 1'b0) extra++;
      tick();
    end
    checks++;
    if (extra != 0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL level_single: got %0d extra valid cycles, overrun=%b expected 0, 0",
               extra, overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [N_ELEM*ELEM_W-1:0] a, b;
    bit to;
    for (int i = 0; i < N_BYTES; i++) begin
      a[8*i +: 8] = 8'(8'h10 + i);
      b[8*i +: 8] = 8'(8'hC0 + i);
    end
    pulse_done(a);
    collect(FRAME_LEN - 1, 4'b1111, 100, to);
    checks++;
    if (out_last !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_at_last: got v=%b l=%b expected 1 1", out_valid, out_last);
    end
    out_ready = 1'b1;
    C_flat    = b;
    done_in   = 1'b1;
    tick();
    done_in   = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== b[7:0] || out_last !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got v=%b d=%h l=%b expected 1 %h 0",
               out_valid, out_data, out_last, b[7:0]);
    end
    collect(FRAME_LEN, 4'b1111, 100, to);
    check_frame("b2b_new", b, 0, FRAME_LEN);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_overrun();
    logic [N_ELEM*ELEM_W-1:0] a, b;
    bit to;
    for (int i = 0; i < N_BYTES; i++) begin
      a[8*i +: 8] = 8'(8'h30 + 3 * i);
      b[8*i +: 8] = 8'hFF;
    end
    pulse_done(a);
    collect(7, 4'b1111, 100, to);
    pulse_done(b);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    collect(FRAME_LEN - 7, 4'b1111, 100, to);
    check_frame("overrun_rest", a, 7, FRAME_LEN - 7);
    tick();
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_sticky: got o=%b v=%b expected 1 0", overrun, out_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic [N_ELEM*ELEM_W-1:0] a, b;
    bit to;
    for (int i = 0; i < N_BYTES; i++) begin
      a[8*i +: 8] = 8'(8'h77 + i);
      b[8*i +: 8] = 8'(8'h01 + 2 * i);
    end
    pulse_done(a);
    collect(5, 4'b1111, 100, to);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, busy, overrun, out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_state: got v=%b b=%b o=%b l=%b expected 0 0 0 0",
               out_valid, busy, overrun, out_last);
    end
    tick();
    pulse_done(b);
    collect(FRAME_LEN, 4'b1111, 100, to);
    check_frame("midreset_restart", b, 0, FRAME_LEN);
  endtask

`ifdef RESULT_CHECKSUM_EN
  task automatic test_checksum();
    logic [N_ELEM*ELEM_W-1:0] c;
    bit to;
    c = '0;
    c[15:0] = 16'h1234;
    pulse_done(c);
    collect(FRAME_LEN, 4'b1011, 200, to);
    checks++;
    if (rx_data.size() != 19 || rx_data[18] !== 8'h26 || rx_last[18] !== 1'b1) begin
      errors++;
      $display("FAIL checksum_byte: got n=%0d expected 19 bytes ending 26 with last", rx_data.size());
    end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    done_in   = 1'b0;
    out_ready = 1'b0;
    C_flat    = '0;
    #1;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_level_done();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
`ifdef RESULT_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_result_serializer.md
Name: matmul_result_serializer

Overview:
Downstream stage of the 3x3 matrix multiplier. It captures the 144-bit packed result (nine 16-bit elements) when the multiplier signals done. It then streams the result out one byte per handshake over an 8-bit valid/ready interface that drives the chip's dedicated output pins. It decouples the single-cycle result from a slow, back-pressured output path.

Parameters:
N_ELEM, 9, number of result elements in a frame
ELEM_W, 16, bits per element; must be a multiple of 8
N_BYTES, N_ELEM*ELEM_W/8 (=18), derived localparam; payload bytes per frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
done_in  input  1  multiplier done; C_flat is valid in every cycle done_in=1
C_flat  input  N_ELEM*ELEM_W  packed result; element k at [16k+15:16k]
out_data  output  8  current output byte
out_valid  output  1  out_data holds a valid byte
out_ready  input  1  consumer accepts the byte this cycle
out_last  output  1  qualifies the final byte of a frame (only meaningful with out_valid)
busy  output  1  frame capture held / transmission in progress
overrun  output  1  sticky; a new result arrived while busy and was dropped

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: out_valid=0, out_last=0, out_data=0, busy=0, overrun=0, byte index=0, done_q=0, state=IDLE. Reset mid-frame aborts the frame immediately, with no partial completion.
- Edge detect: done_q registers done_in. capture_ev = done_in & ~done_q. A done_in held high for multiple cycles yields exactly one capture.
- FSM states: IDLE, SEND.
- IDLE, capture_ev:
  - shadow <= C_flat, idx <= 0, state <= SEND.
  - out_valid=1 and busy=1 from the next cycle; capture-to-first-valid latency is 1 cycle.
- IDLE, no capture_ev: out_valid=0, busy=0.
- SEND: out_data = shadow[8*idx+7 : 8*idx].
  - Byte order: little-endian, element 0 low byte first, element 8 high byte last.
  - Transfer occurs when out_valid & out_ready. On a transfer, idx <= idx+1.
  - While out_valid=1 and out_ready=0, out_data, out_last and out_valid hold stable.
- Last-byte transfer, no capture_ev: state <= IDLE; out_valid=0 next cycle.
- Last-byte transfer, capture_ev in the same cycle:
  - The new capture is accepted: shadow reloaded, idx <= 0, stay in SEND, out_valid stays 1 (back-to-back frames, no bubble).
  - overrun is not set.
- capture_ev in SEND on any other cycle: the new result is dropped, overrun <= 1, and the current frame continues unaltered.
- overrun is cleared only by rst.
- out_last = out_valid & (idx == final index).
- busy = (state == SEND).
- out_data is driven from registered state only (shadow + idx mux). There is no combinational path from out_ready to out_valid or out_data.

Optional Feature:
Macro RESULT_CHECKSUM_EN.
- Defined:
  - Each frame carries N_BYTES+1 bytes. Byte N_BYTES is the XOR of all N_BYTES payload bytes, computed from shadow at capture or accumulated during transfer.
  - out_last marks the checksum byte. The back-to-back rule applies to the checksum-byte transfer.
- Undefined: exactly N_BYTES bytes per frame, out_last on byte N_BYTES-1, and no checksum logic is synthesized.

Test Plan:
1. Reset check: assert rst 2 cycles mid-frame (after 5 bytes) -> next cycle out_valid=0, busy=0, overrun=0, out_last=0. A following capture starts at byte 0.
2. Single frame, out_ready=1 constantly, C0=0x1234, C8=0xBEEF, others=0x0000:
   - out_valid rises 1 cycle after the done_in rising edge.
   - Bytes are 0x34,0x12, then 0x00 x14, then 0xEF,0xBE.
   - out_last only on 0xBE; out_valid low the cycle after.
3. Backpressure: out_ready pattern 1,0,0,1 repeating -> 18 bytes in order, no duplicates or skips. out_data and out_last stable through every ready=0 cycle.
4. Level-held done: done_in high 6 cycles with constant C_flat -> exactly one frame, overrun=0.
5. Overrun and back-to-back:
   - A second done_in rising edge at byte 7 -> overrun=1 (sticky), the original frame completes unchanged.
   - A rising edge coincident with the last-byte transfer -> out_valid stays 1 and the next byte is the new frame's byte 0.
6. RESULT_CHECKSUM_EN defined with C0=0x1234, rest 0x0000 -> 19 bytes; byte 18 = 0x34^0x12 = 0x26 with out_last=1.
